instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Parametrised, writable successor to the fixed combinational program ROM.
- Synchronous-read instruction store feeding the CPU fetch stage.
- Adds a byte-stream boot-load port: the host streams a program in at run time while the CPU is held off via oBusy.
- Sits between the fetch unit (iAddress/oInstruction) and the UART/host loader.

Parameters:
- INSTR_WIDTH, 28, instruction word width in bits.
- ADDR_WIDTH, 16, width of iAddress.
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- BYTES_PER_WORD, ceil(INSTR_WIDTH/8) = 4, load bytes per instruction word (derived localparam).
- DEFAULT_INSTR, {LED opcode, 24'b10101010}, returned for out-of-range addresses.
- STALL_INSTR, {NOP opcode, 24'b0}, returned while busy and after reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- iAddress  in  ADDR_WIDTH  fetch address.
- oInstruction  out  INSTR_WIDTH  registered instruction.
- iLoadStart  in  1  one-cycle pulse; begins a load at word 0.
- iLoadLength  in  ADDR_WIDTH  number of words to load; sampled with iLoadStart.
- iLoadData  in  8  load byte.
- iLoadValid  in  1  iLoadData is valid this cycle.
- oLoadReady  out  1  byte is accepted when iLoadValid && oLoadReady.
- oBusy  out  1  load in progress; CPU must stall.
- oLoadDone  out  1  one-cycle pulse on load completion.
- oLoadError  out  1  sticky; set by a rejected start, cleared by the next accepted start.

Behaviour:
- Reset (async) values: oInstruction=STALL_INSTR, oBusy=0, oLoadReady=0, oLoadDone=0, oLoadError=0, FSM=IDLE.
  - Memory array is not cleared by reset.
- Read path, 1-cycle latency: oInstruction(n+1) = mem[iAddress(n)] if iAddress(n) < DEPTH, else DEFAULT_INSTR.
  - While oBusy=1, oInstruction = STALL_INSTR regardless of iAddress.
- FSM states: IDLE, RECV, WRITE, DONE.
  - IDLE:
    - iLoadStart with iLoadLength=0 -> oLoadError=1, stay IDLE.
    - iLoadStart with iLoadLength>DEPTH -> oLoadError=1, stay IDLE.
    - Otherwise latch length, clear word address, clear byte count, clear oLoadError -> RECV.
  - RECV:
    - oLoadReady=1, oBusy=1.
    - Each handshake shifts the byte into the assembly register. Little-endian: byte k fills bits [8k+7:8k].
    - Bits at and above INSTR_WIDTH are discarded.
    - On handshake of byte BYTES_PER_WORD-1 -> WRITE.
  - WRITE:
    - oLoadReady=0. Writes the assembled word to mem[word address] in one cycle.
    - If word address == length-1 -> DONE; else increment word address, clear byte count -> RECV.
  - DONE: oLoadDone=1 for one cycle, oBusy=0 in the same cycle -> IDLE.
- iLoadStart while in RECV/WRITE/DONE: ignored, sets oLoadError, load continues unaffected.
- iLoadValid while oLoadReady=0: byte is not consumed; the source must hold it (valid/ready rule).
- Gaps in iLoadValid stall assembly indefinitely; there is no timeout.
- Reset mid-load: immediate return to IDLE, oBusy=0.
  - Words already written remain; partially assembled word is dropped.
  - oLoadDone is not pulsed.
- Words beyond length keep previous contents.
- Word address counter is ADDR_WIDTH bits wide and never wraps, because length <= DEPTH is enforced.

Decomposition:
- Shared definitions file gains NOP/LED instruction constants used as STALL_INSTR/DEFAULT_INSTR defaults, alongside existing opcode and register macros.
- FSM state encodings are localparams inside the block.
- One sub-module: sync_ram_sp (single port, synchronous read, one write port, parameters WIDTH/DEPTH). Its read uses the fetch address; its write uses the loader address.

Test Plan:
- Reset then iAddress=0 with no load -> oInstruction=STALL_INSTR on reset; next cycle returns array contents; oBusy=0.
- iLoadStart, iLoadLength=2, bytes 01 23 45 67 89 AB CD EF -> oLoadDone pulse after the 2nd WRITE.
  - Reading 0 gives 28'h7452301 (top nibble 6 dropped); reading 1 gives 28'hFCDAB89.
- Same load with iLoadValid toggling every other cycle -> identical contents; oLoadReady low in WRITE cycles; no byte lost or duplicated.
- iAddress=DEPTH (256) -> oInstruction=DEFAULT_INSTR one cycle later.
- iLoadStart during RECV -> oLoadError=1, load completes normally.
  - iLoadStart with iLoadLength=0 in IDLE -> oLoadError=1, oBusy stays 0.
- Reset asserted after 5 bytes of a 2-word load -> oBusy=0 immediately, word 0 holds new data, word 1 unchanged, no oLoadDone.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared instruction-set definitions: opcodes, register indices and the
// canned NOP/LED words used by the instruction store.
package instruction_memory_pkg;

  localparam int unsigned OpcodeWidth  = 4;
  localparam int unsigned OperandWidth = 24;
  localparam int unsigned InstrWidth   = OpcodeWidth + OperandWidth;

  localparam logic [OpcodeWidth-1:0] OpNop    = 4'h0;
  localparam logic [OpcodeWidth-1:0] OpLoad   = 4'h1;
  localparam logic [OpcodeWidth-1:0] OpStore  = 4'h2;
  localparam logic [OpcodeWidth-1:0] OpAdd    = 4'h3;
  localparam logic [OpcodeWidth-1:0] OpSub    = 4'h4;
  localparam logic [OpcodeWidth-1:0] OpJump   = 4'h5;
  localparam logic [OpcodeWidth-1:0] OpBranch = 4'h6;
  localparam logic [OpcodeWidth-1:0] OpLed    = 4'hE;
  localparam logic [OpcodeWidth-1:0] OpHalt   = 4'hF;

  localparam logic [3:0] RegZero = 4'd0;
  localparam logic [3:0] RegAcc  = 4'd1;
  localparam logic [3:0] RegTmp  = 4'd2;
  localparam logic [3:0] RegSp   = 4'd15;

  localparam logic [InstrWidth-1:0] NopInstr = {OpNop, 24'h000000};
  localparam logic [InstrWidth-1:0] LedInstr = {OpLed, 24'b10101010};

endpackage

// File: rtl/sync_ram_sp.sv
// Word RAM with registered read; one write port and one read port sharing the clock.
module sync_ram_sp #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: contents must survive a reset of the loader.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/instruction_memory.sv
// Synchronous-read instruction store with a byte-stream boot loader that
// holds the CPU off (oBusy) while a program is streamed in.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH             = 28,
  parameter int unsigned ADDR_WIDTH              = 16,
  parameter int unsigned DEPTH                   = 256,
  parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = INSTR_WIDTH'(LedInstr),
  parameter logic [INSTR_WIDTH-1:0] STALL_INSTR   = INSTR_WIDTH'(NopInstr)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  input  logic                   iLoadStart,
  input  logic [ADDR_WIDTH-1:0]  iLoadLength,
  input  logic [7:0]             iLoadData,
  input  logic                   iLoadValid,
  output logic                   oLoadReady,
  output logic                   oBusy,
  output logic                   oLoadDone,
  output logic                   oLoadError
);

  localparam int unsigned BYTES_PER_WORD = (INSTR_WIDTH + 7) / 8;
  localparam int unsigned AsmWidth       = BYTES_PER_WORD * 8;
  localparam int unsigned RamAw          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW           = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CntW-1:0]     LastByte = CntW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} load_state_e;

  load_state_e            state_q;
  logic [ADDR_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0]  word_addr_q;
  logic [CntW-1:0]        byte_cnt_q;
  logic [AsmWidth-1:0]    asm_q;
  logic                   stall_q;
  logic                   in_range_q;
  logic [INSTR_WIDTH-1:0] ram_rdata;
  logic                   ram_we;

  // Loader FSM; all handshake/status outputs are registered here.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_addr_q <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      oLoadReady  <= 1'b0;
      oBusy       <= 1'b0;
      oLoadDone   <= 1'b0;
      oLoadError  <= 1'b0;
    end else begin
      oLoadDone <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iLoadStart) begin
            if (iLoadLength == '0 || {1'b0, iLoadLength} > DepthW) begin
              oLoadError <= 1'b1;
            end else begin
              len_q       <= iLoadLength;
              word_addr_q <= '0;
              byte_cnt_q  <= '0;
              oLoadError  <= 1'b0;
              oLoadReady  <= 1'b1;
              oBusy       <= 1'b1;
              state_q     <= StRecv;
            end
          end
        end
        StRecv: begin
          if (iLoadValid) begin
            asm_q[{byte_cnt_q, 3'b000} +: 8] <= iLoadData;
            if (byte_cnt_q == LastByte) begin
              oLoadReady <= 1'b0;
              state_q    <= StWrite;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StWrite: begin
          if (word_addr_q == len_q - 1'b1) begin
            oBusy     <= 1'b0;
            oLoadDone <= 1'b1;
            state_q   <= StDone;
          end else begin
            word_addr_q <= word_addr_q + 1'b1;
            byte_cnt_q  <= '0;
            oLoadReady  <= 1'b1;
            state_q     <= StRecv;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (iLoadStart && state_q != StIdle) begin
        oLoadError <= 1'b1;
      end
    end
  end

  // stall_q covers the first cycle after reset, before the RAM has produced a read.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_q    <= 1'b1;
      in_range_q <= 1'b0;
    end else begin
      stall_q    <= 1'b0;
      in_range_q <= ({1'b0, iAddress} < DepthW);
    end
  end

  assign ram_we = (state_q == StWrite);

  sync_ram_sp #(
    .WIDTH(INSTR_WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (Clock),
    .we_i   (ram_we),
    .waddr_i(word_addr_q[RamAw-1:0]),
    .wdata_i(asm_q[INSTR_WIDTH-1:0]),
    .raddr_i(iAddress[RamAw-1:0]),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    oInstruction = DEFAULT_INSTR;
    if (stall_q || oBusy) begin
      oInstruction = STALL_INSTR;
    end else if (in_range_q) begin
      oInstruction = ram_rdata;
    end
  end

  generate
    if (AsmWidth > INSTR_WIDTH) begin : g_pad
      logic unused_asm;
      assign unused_asm = ^asm_q[AsmWidth-1:INSTR_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reset, loads, handshake gaps,
// error cases, out-of-range reads and reset in the middle of a load.
module tb_instruction_memory;

  localparam logic [27:0] Stall   = 28'h0000000;
  localparam logic [27:0] Default = 28'hE0000AA;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iAddress;
  logic [27:0] oInstruction;
  logic        iLoadStart;
  logic [15:0] iLoadLength;
  logic [7:0]  iLoadData;
  logic        iLoadValid;
  logic        oLoadReady;
  logic        oBusy;
  logic        oLoadDone;
  logic        oLoadError;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instruction_memory dut (
    .Clock       (clk),
    .Reset       (rst),
    .iAddress    (iAddress),
    .oInstruction(oInstruction),
    .iLoadStart  (iLoadStart),
    .iLoadLength (iLoadLength),
    .iLoadData   (iLoadData),
    .iLoadValid  (iLoadValid),
    .oLoadReady  (oLoadReady),
    .oBusy       (oBusy),
    .oLoadDone   (oLoadDone),
    .oLoadError  (oLoadError)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!oLoadReady && guard < 20) begin
      tick();
      guard++;
    end
    if (!oLoadReady) check_eq("ready_timeout", {31'b0, oLoadReady}, 32'd1);
    iLoadData  = b;
    iLoadValid = 1'b1;
    tick();
    iLoadValid = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] len);
    iLoadStart  = 1'b1;
    iLoadLength = len;
    tick();
    iLoadStart  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr, input logic [27:0] exp);
    iAddress = addr;
    tick();
    check_eq(tag, {4'b0, oInstruction}, {4'b0, exp});
  endtask

  logic [7:0] load_a [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] load_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iAddress = '0; iLoadStart = 1'b0; iLoadLength = '0;
    iLoadData = '0; iLoadValid = 1'b0;
    tick();
    tick();
    check_eq("rst_instr", {4'b0, oInstruction}, {4'b0, Stall});
    check_eq("rst_busy",  {31'b0, oBusy},      32'd0);
    check_eq("rst_ready", {31'b0, oLoadReady}, 32'd0);
    check_eq("rst_done",  {31'b0, oLoadDone},  32'd0);
    check_eq("rst_err",   {31'b0, oLoadError}, 32'd0);
    rst = 1'b0;
    check_eq("post_rst_instr", {4'b0, oInstruction}, {4'b0, Stall});
    tick();
    check_eq("idle_busy", {31'b0, oBusy}, 32'd0);

    // Rejected starts
    start_load(16'd0);
    check_eq("len0_err",  {31'b0, oLoadError}, 32'd1);
    check_eq("len0_busy", {31'b0, oBusy},      32'd0);
    start_load(16'd257);
    check_eq("len257_err",  {31'b0, oLoadError}, 32'd1);
    check_eq("len257_busy", {31'b0, oBusy},      32'd0);

    // Two-word load, back-to-back bytes
    start_load(16'd2);
    check_eq("start_err_clr", {31'b0, oLoadError}, 32'd0);
    check_eq("start_busy",    {31'b0, oBusy},      32'd1);
    check_eq("start_ready",   {31'b0, oLoadReady}, 32'd1);
    iAddress = 16'd0;
    for (int i = 0; i < 4; i++) send_byte(load_a[i]);
    check_eq("write0_ready", {31'b0, oLoadReady}, 32'd0);
    check_eq("write0_busy",  {31'b0, oBusy},      32'd1);
    check_eq("busy_stall",   {4'b0, oInstruction}, {4'b0, Stall});
    for (int i = 4; i < 8; i++) send_byte(load_a[i]);
    check_eq("write1_ready", {31'b0, oLoadReady}, 32'd0);
    check_eq("write1_done",  {31'b0, oLoadDone},  32'd0);
    tick();
    check_eq("done_pulse", {31'b0, oLoadDone}, 32'd1);
    check_eq("done_busy",  {31'b0, oBusy},     32'd0);
    tick();
    check_eq("done_clear", {31'b0, oLoadDone}, 32'd0);
    read_chk("a_word0", 16'd0, 28'h7452301);
    read_chk("a_word1", 16'd1, 28'hFCDAB89);
    read_chk("oor_256", 16'd256, Default);
    read_chk("oor_ffff", 16'hFFFF, Default);

    // Load with a one-cycle gap between every byte
    start_load(16'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(load_b[i]);
      if (i == 3 || i == 7) check_eq("gap_write_ready", {31'b0, oLoadReady}, 32'd0);
      tick();
    end
    check_eq("gap_done", {31'b0, oLoadDone}, 32'd1);
    read_chk("b_word0", 16'd0, 28'h4332211);
    read_chk("b_word1", 16'd1, 28'h8776655);

    // Start during RECV is rejected but the load carries on
    start_load(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    iLoadStart = 1'b1; iLoadLength = 16'd0;
    tick();
    iLoadStart = 1'b0;
    check_eq("recv_start_err",   {31'b0, oLoadError}, 32'd1);
    check_eq("recv_start_busy",  {31'b0, oBusy},      32'd1);
    check_eq("recv_start_ready", {31'b0, oLoadReady}, 32'd1);
    send_byte(8'hCC);
    send_byte(8'hDD);
    tick();
    check_eq("c_done", {31'b0, oLoadDone}, 32'd1);
    read_chk("c_word0", 16'd0, 28'hDCCBBAA);
    read_chk("c_word1_kept", 16'd1, 28'h8776655);

    // Reset after five bytes of a two-word load
    start_load(16'd2);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy",  {31'b0, oBusy},      32'd0);
    check_eq("mid_rst_done",  {31'b0, oLoadDone},  32'd0);
    check_eq("mid_rst_ready", {31'b0, oLoadReady}, 32'd0);
    check_eq("mid_rst_instr", {4'b0, oInstruction}, {4'b0, Stall});
    tick();
    rst = 1'b0;
    read_chk("r_word0", 16'd0, 28'h4030201);
    check_eq("r_no_done", {31'b0, oLoadDone}, 32'd0);
    read_chk("r_word1_kept", 16'd1, 28'h8776655);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
